pdp8_iot_seq: RTL and testbench
===============================

PDP8_IOT_SEQ -- requirements
Module: pdp8_iot_seq

Interface
REQ-001 clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 start  input  1  one-cycle request to execute the instruction on ir.
REQ-004 ir  input  12  instruction word; IOT when ir[11:9]=3'o6.
REQ-005 ac_in  input  12  accumulator value presented with start.
REQ-006 io_selected, io_skip, io_interrupt  input  1 each  device-side responses, combinational from devices.
REQ-007 io_data_in  input  12  device data, ORed into AC when selected.
REQ-008 io_clear_ac  input  1  device request to clear AC before the OR.
REQ-009 int_ack  input  1  CPU has taken the interrupt.
REQ-010 state  output  4  bus phase: F0=4'b0000, F1=4'b0001, F2=4'b0010, F3=4'b0011, idle=4'b1000.
REQ-011 iot  output  1  high only in F1.
REQ-012 io_select  output  6  ir[8:3], held F0..F3.
REQ-013 mb  output  12  latched instruction, held F0..F3.
REQ-014 busy, done, skip, nodev  output  1 each  status; done is a one-cycle pulse.
REQ-015 ac_out  output  12  resulting accumulator, valid with done, held until next done.
REQ-016 ion, int_req  output  1 each  interrupt enable and qualified request.

Function
REQ-017 Idle: state=idle, iot=0, busy=0; start with ir[11:9]=6 latches ir->mb, ac_in internally, enters F0 next cycle; start with any other opcode is ignored (no done).
REQ-018 Sequence is fixed: F0 -> F1 -> F2 -> F3 -> idle, one clock each; done pulses in the cycle after F3; latency start->done = 5 clocks.
REQ-019 busy=1 from F0 through F3; start while busy is ignored.
REQ-020 In F1 with io_select!=0: sample io_selected; if 1, skip<=io_skip, ac<=(io_clear_ac?0:ac)|io_data_in; if 0, nodev<=1, skip<=0, ac unchanged.
REQ-021 Device 00 handled internally, io_selected ignored, nodev=0: mb[2:0]=0 SKON: skip<=ion, then ion<=0; =1 ION: ion<=1, delay<=1; =2 IOF: ion<=0, delay<=0; other codes no-op.
REQ-022 skip, nodev, ac_out update only at done; skip and nodev clear at next accepted start.
REQ-023 int_req = ion & io_interrupt & ~delay & ~busy, combinational.
REQ-024 delay clears on the done of the instruction following the ION, so one further instruction completes before int_req may rise.
REQ-025 int_ack clears ion and delay next cycle; int_ack has priority over a same-cycle ION completion.
REQ-026 io_interrupt is level-sensitive; no latching inside this block.

Reset
REQ-027 While reset=0: state=idle, iot=0, io_select=0, mb=0, busy=0, done=0, skip=0, nodev=0, ac_out=0, ion=0, delay=0.
REQ-028 Reset mid-sequence aborts immediately with no done; first start after release begins a clean F0.

Structure
REQ-029 Shared package pdp8_defs holds the F0..F3/idle state encodings, IOT opcode 3'o6 and internal device code 6'o00.
REQ-030 Single module; phase counter and interrupt-enable logic may be split into sub-module pdp8_ion_ctl (ion, delay, int_req).

Verification
REQ-031 ir=12'o6133, ac_in=0, device 13 selected with io_skip=1 -> state 0,1,2,3 on consecutive cycles, iot only in F1, done 5 clocks after start, skip=1.
REQ-032 ir=12'o6404, io_selected=0 -> nodev=1, skip=0, ac_out=ac_in.
REQ-033 ac_in=12'o7070, io_clear_ac=1, io_data_in=12'o0017 -> ac_out=12'o0017; with io_clear_ac=0 -> 12'o7077.
REQ-034 ION (6001), io_interrupt=1 -> int_req stays 0 through the next instruction's done, rises after it; int_ack -> ion=0, int_req=0 next cycle.
REQ-035 SKON (6000) with ion=1 -> skip=1, ion=0; second start pulsed during F2 -> ignored, single done.
REQ-036 reset=0 asserted during F2 -> all outputs at reset values immediately, no done pulse.

Source files
------------

// File: rtl/pdp8_iot_seq_pkg.sv
// Shared encodings for the PDP-8 IOT bus sequencer: phase codes, the IOT opcode
// and the function codes of the internal (device 00) interrupt controller.
package pdp8_defs;

    typedef enum logic [3:0] {
        PH_F0   = 4'b0000,
        PH_F1   = 4'b0001,
        PH_F2   = 4'b0010,
        PH_F3   = 4'b0011,
        PH_IDLE = 4'b1000
    } phase_t;

    localparam logic [2:0] IOT_OP       = 3'o6;
    localparam logic [5:0] DEV_INTERNAL = 6'o00;

    localparam logic [2:0] FN_SKON = 3'd0;
    localparam logic [2:0] FN_ION  = 3'd1;
    localparam logic [2:0] FN_IOF  = 3'd2;

endpackage

// File: rtl/pdp8_iot_seq_ion_ctl.sv
// Interrupt enable, one-instruction ION delay and the qualified interrupt request.
module pdp8_ion_ctl (
    input  logic clk,
    input  logic reset,
    input  logic int_ack,
    input  logic io_interrupt,
    input  logic busy,
    input  logic ion_on,
    input  logic ion_off,
    input  logic dly_off,
    input  logic finish,
    input  logic finish_ion,
    output logic ion,
    output logic int_req
);

    logic delay;

    // int_ack outranks any same-cycle enable coming from an ION in F1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ion   <= 1'b0;
            delay <= 1'b0;
        end else if (int_ack) begin
            ion   <= 1'b0;
            delay <= 1'b0;
        end else begin
            if (ion_on) begin
                ion   <= 1'b1;
                delay <= 1'b1;
            end else if (ion_off) begin
                ion <= 1'b0;
            end
            // The delay survives the ION's own completion and drops at the next one.
            if (dly_off || (finish && !finish_ion)) begin
                delay <= 1'b0;
            end
        end
    end

    assign int_req = ion & io_interrupt & ~delay & ~busy;

endmodule

// File: rtl/pdp8_iot_seq.sv
// PDP-8 IOT bus sequencer: runs one I/O transfer through phases F0..F3 and
// returns the updated accumulator, skip and no-device status.
module pdp8_iot_seq
    import pdp8_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] ir,
    input  logic [11:0] ac_in,
    input  logic        io_selected,
    input  logic        io_skip,
    input  logic        io_interrupt,
    input  logic [11:0] io_data_in,
    input  logic        io_clear_ac,
    input  logic        int_ack,
    output logic [3:0]  state,
    output logic        iot,
    output logic [5:0]  io_select,
    output logic [11:0] mb,
    output logic        busy,
    output logic        done,
    output logic        skip,
    output logic        nodev,
    output logic [11:0] ac_out,
    output logic        ion,
    output logic        int_req
);

    // Handshake: start is a one-cycle request sampled only while idle (ignored
    // when busy or for non-IOT opcodes); done is a one-cycle response with
    // ac_out/skip/nodev valid, and there is no backpressure on either side.
    phase_t      cur_state, next_state;
    logic        accept, in_f1, finish, dev_internal;
    logic [2:0]  fn;
    logic [11:0] ac_r;
    logic        skip_p, nodev_p;
    logic        ion_on, ion_off, dly_off, finish_ion;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur_state <= PH_IDLE;
        else        cur_state <= next_state;
    end

    always_comb begin
        next_state = cur_state;
        accept     = 1'b0;
        case (cur_state)
            PH_IDLE: begin
                if (start && ir[11:9] == IOT_OP) begin
                    next_state = PH_F0;
                    accept     = 1'b1;
                end
            end
            PH_F0:   next_state = PH_F1;
            PH_F1:   next_state = PH_F2;
            PH_F2:   next_state = PH_F3;
            PH_F3:   next_state = PH_IDLE;
            default: next_state = PH_IDLE;
        endcase
    end

    assign state        = cur_state;
    assign busy         = (cur_state != PH_IDLE);
    assign in_f1        = (cur_state == PH_F1);
    assign finish       = (cur_state == PH_F3);
    assign iot          = in_f1;
    assign io_select    = busy ? mb[8:3] : 6'o00;
    assign dev_internal = (mb[8:3] == DEV_INTERNAL);
    assign fn           = mb[2:0];

    assign ion_on     = in_f1 & dev_internal & (fn == FN_ION);
    assign ion_off    = in_f1 & dev_internal & ((fn == FN_SKON) | (fn == FN_IOF));
    assign dly_off    = in_f1 & dev_internal & (fn == FN_IOF);
    assign finish_ion = dev_internal & (fn == FN_ION);

    // Working results build up in F1 and only become visible at done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mb      <= '0;
            ac_r    <= '0;
            skip_p  <= 1'b0;
            nodev_p <= 1'b0;
            done    <= 1'b0;
            skip    <= 1'b0;
            nodev   <= 1'b0;
            ac_out  <= '0;
        end else begin
            done <= finish;
            if (accept) begin
                mb      <= ir;
                ac_r    <= ac_in;
                skip_p  <= 1'b0;
                nodev_p <= 1'b0;
                skip    <= 1'b0;
                nodev   <= 1'b0;
            end
            if (in_f1) begin
                if (dev_internal) begin
                    if (fn == FN_SKON) skip_p <= ion;
                end else if (io_selected) begin
                    skip_p <= io_skip;
                    ac_r   <= (io_clear_ac ? 12'o0000 : ac_r) | io_data_in;
                end else begin
                    nodev_p <= 1'b1;
                end
            end
            if (finish) begin
                skip   <= skip_p;
                nodev  <= nodev_p;
                ac_out <= ac_r;
            end
        end
    end

    pdp8_ion_ctl u_ion_ctl (
        .clk          (clk),
        .reset        (reset),
        .int_ack      (int_ack),
        .io_interrupt (io_interrupt),
        .busy         (busy),
        .ion_on       (ion_on),
        .ion_off      (ion_off),
        .dly_off      (dly_off),
        .finish       (finish),
        .finish_ion   (finish_ion),
        .ion          (ion),
        .int_req      (int_req)
    );

endmodule

// File: tb/tb_pdp8_iot_seq.sv
// Bench for pdp8_iot_seq: directed IOT scenarios plus random instructions,
// checked against an instruction-level model through an expected-result queue.
module tb_pdp8_iot_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [11:0] ir = '0;
    logic [11:0] ac_in = '0;
    logic        io_selected = 1'b0;
    logic        io_skip = 1'b0;
    logic        io_interrupt = 1'b0;
    logic [11:0] io_data_in = '0;
    logic        io_clear_ac = 1'b0;
    logic        int_ack = 1'b0;
    logic [3:0]  state;
    logic        iot;
    logic [5:0]  io_select;
    logic [11:0] mb;
    logic        busy, done, skip, nodev;
    logic [11:0] ac_out;
    logic        ion, int_req;

    int err_cnt = 0;
    int chk_cnt = 0;
    int done_cnt = 0;

    // expected {ac_out, skip, nodev} per accepted instruction
    logic [13:0] exp_q[$];

    // instruction-level model of architectural state
    logic        m_ion = 1'b0;
    logic        m_delay = 1'b0;
    logic [11:0] m_ac_out = '0;

    pdp8_iot_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ir           (ir),
        .ac_in        (ac_in),
        .io_selected  (io_selected),
        .io_skip      (io_skip),
        .io_interrupt (io_interrupt),
        .io_data_in   (io_data_in),
        .io_clear_ac  (io_clear_ac),
        .int_ack      (int_ack),
        .state        (state),
        .iot          (iot),
        .io_select    (io_select),
        .mb           (mb),
        .busy         (busy),
        .done         (done),
        .skip         (skip),
        .nodev        (nodev),
        .ac_out       (ac_out),
        .ion          (ion),
        .int_req      (int_req)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want finish earlier");
        $display("Result: errors=%0d of %0d checks", err_cnt + 1, chk_cnt + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pops an expectation on every done pulse
    always @(negedge clk) begin
        logic [13:0] e;
        if (reset && done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk_cnt++;
                err_cnt++;
                $display("FAIL unexpected_done: done=1 with no pending instruction at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("ac_out", ac_out, e[13:2]);
                check("skip",   skip,   e[1]);
                check("nodev",  nodev,  e[0]);
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_state", state, 4'b1000);
        check("rst_iot", iot, 0);
        check("rst_io_select", io_select, 0);
        check("rst_mb", mb, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_skip", skip, 0);
        check("rst_nodev", nodev, 0);
        check("rst_ac_out", ac_out, 0);
        check("rst_ion", ion, 0);
        check("rst_int_req", int_req, 0);
    endtask

    // driver: one instruction, held device responses, optional start poke in F2
    // and optional int_ack during F1
    task automatic issue(input logic [11:0] i, input logic [11:0] a, input logic sel,
                         input logic sk, input logic clr, input logic irq,
                         input logic [11:0] din, input logic poke, input logic ack_f1);
        logic        is_iot;
        logic [5:0]  dev;
        logic [2:0]  fn;
        logic [11:0] e_ac;
        logic        e_skip, e_nodev;
        is_iot = (i[11:9] == 3'o6);
        dev    = i[8:3];
        fn     = i[2:0];
        @(negedge clk);
        ir = i; ac_in = a; io_selected = sel; io_skip = sk; io_clear_ac = clr;
        io_interrupt = irq; io_data_in = din; start = 1'b1;
        if (is_iot) begin
            e_ac = a; e_skip = 1'b0; e_nodev = 1'b0;
            if (dev == 6'o00) begin
                if (fn == 3'd0) begin e_skip = m_ion; m_ion = 1'b0; end
                else if (fn == 3'd1) begin m_ion = 1'b1; m_delay = 1'b1; end
                else if (fn == 3'd2) begin m_ion = 1'b0; m_delay = 1'b0; end
            end else if (sel) begin
                e_skip = sk;
                e_ac   = (clr ? 12'o0000 : a) | din;
            end else begin
                e_nodev = 1'b1;
            end
            if (!(dev == 6'o00 && fn == 3'd1)) m_delay = 1'b0;
            exp_q.push_back({e_ac, e_skip, e_nodev});
        end
        if (ack_f1) begin m_ion = 1'b0; m_delay = 1'b0; end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (ack_f1 && k == 1) int_ack = 1'b1;
            if (ack_f1 && k == 2) int_ack = 1'b0;
            if (poke && k == 2) begin start = 1'b1; ir = 12'o6001; end
            if (poke && k == 3) begin start = 1'b0; ir = i; end
            #1;
            if (is_iot) begin
                check("phase", state, k);
                check("iot", iot, (k == 1));
                check("busy", busy, 1);
                check("io_select", io_select, dev);
                check("mb", mb, i);
                check("int_req_busy", int_req, 0);
                if (k == 0) begin
                    check("skip_cleared", skip, 0);
                    check("nodev_cleared", nodev, 0);
                end
            end else begin
                check("ignored_state", state, 4'b1000);
                check("ignored_busy", busy, 0);
            end
            check("ac_out_held", ac_out, m_ac_out);
        end
        @(negedge clk);
        #1;
        check("end_state", state, 4'b1000);
        check("end_iot", iot, 0);
        check("pending_done", exp_q.size(), 0);
        if (is_iot) m_ac_out = e_ac;
        check("ion", ion, m_ion);
        check("int_req", int_req, m_ion & irq & ~m_delay);
    endtask

    task automatic ack_idle();
        @(negedge clk);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        m_ion = 1'b0;
        m_delay = 1'b0;
        #1;
        check("ack_ion", ion, 0);
        check("ack_int_req", int_req, 0);
    endtask

    initial begin
        int          saved;
        logic [11:0] i;
        logic [2:0]  op;
        int          r;

        // reset
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b1;

        // device 13 with skip
        issue(12'o6133, 12'o0000, 1, 1, 0, 0, 12'o0000, 0, 0);
        // no device answers
        issue(12'o6404, 12'o1234, 0, 1, 0, 0, 12'o7777, 0, 0);
        // clear-then-OR and plain OR
        issue(12'o6051, 12'o7070, 1, 0, 1, 0, 12'o0017, 0, 0);
        issue(12'o6051, 12'o7070, 1, 0, 0, 0, 12'o0017, 0, 0);
        // non-IOT start is ignored
        issue(12'o1234, 12'o4321, 1, 1, 0, 0, 12'o0001, 0, 0);
        // ION delay, then int_req after the following instruction
        issue(12'o6001, 12'o0000, 0, 0, 0, 1, 12'o0000, 0, 0);
        issue(12'o6133, 12'o0005, 1, 0, 0, 1, 12'o0000, 0, 0);
        ack_idle();
        // SKON with ion set, extra start during F2
        issue(12'o6001, 12'o0000, 0, 0, 0, 0, 12'o0000, 0, 0);
        issue(12'o6133, 12'o0000, 1, 0, 0, 0, 12'o0000, 0, 0);
        issue(12'o6000, 12'o0007, 0, 0, 0, 1, 12'o0000, 1, 0);
        // int_ack beats a same-cycle ION
        issue(12'o6001, 12'o0000, 0, 0, 0, 1, 12'o0000, 0, 1);

        // reset asserted in F2
        saved = done_cnt;
        @(negedge clk);
        ir = 12'o6133; ac_in = 12'o0055; io_selected = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b1;
        m_ion = 1'b0; m_delay = 1'b0; m_ac_out = 12'o0000;
        repeat (6) @(negedge clk);
        check("abort_no_done", done_cnt, saved);
        issue(12'o6133, 12'o0042, 1, 1, 0, 0, 12'o0100, 0, 0);

        // random instructions
        for (int n = 0; n < 45; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                op = 3'($urandom_range(0, 6));
                if (op == 3'o6) op = 3'o7;
                i = {op, 9'($urandom_range(0, 511))};
            end else if (r < 5) begin
                i = {3'o6, 6'o00, 3'($urandom_range(0, 7))};
            end else begin
                i = {3'o6, 6'($urandom_range(1, 63)), 3'($urandom_range(0, 7))};
            end
            issue(i, 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
                  (i[11:9] == 3'o6) && ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 6) == 0));
            if ($urandom_range(0, 9) == 0) ack_idle();
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
